// File: rtl/eth_frame_tx.sv
// eth_frame_tx: serialises a 60-byte st_eth_packet into an 802.3 frame
// (preamble, SFD, packet, optional FCS) on a byte-wide valid/ready stream,
// then enforces the inter-frame gap. One request can wait in a pending slot.
// Optional feature macro: ETH_TX_FCS_EN (CRC-32 generation and 4 FCS bytes).
module eth_frame_tx #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_CYCLES     = 48
) (
  input  logic         eth_clk,
  input  logic         rst_in,
  input  logic         send_packet,
  input  logic [479:0] eth_packet,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         busy,
  output logic         dropped
);

  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, FCS, IFG} state_t;

  state_t             state, state_nxt;
  logic [5:0]         byte_cnt;
  logic [IFG_W-1:0]   ifg_cnt;
  logic [479:0]       shift_reg;
  logic [479:0]       pend_data;
  logic               pend_full;

  logic accept, phase_done, ifg_done, start_ok;
  logic use_pend, use_in, latch_req, drop_req;

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] crc_inv;

  // One byte of reflected CRC-32 (poly 0xEDB88320), data LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_inv = ~crc;
`endif

  assign accept   = tx_valid && tx_ready;
  assign ifg_done = (state == IFG) && (ifg_cnt == IFG_W'(IFG_CYCLES - 1));
  // A new frame may start from IDLE or straight out of the final gap cycle.
  assign start_ok = (state == IDLE) || ifg_done;
  // The pending slot has priority; a fresh strobe starts directly only when
  // the slot is empty, otherwise it is parked or, with the slot full, dropped.
  assign use_pend  = start_ok && pend_full;
  assign use_in    = start_ok && !pend_full && send_packet;
  assign latch_req = send_packet && !use_in && !pend_full;
  assign drop_req  = send_packet && !use_in && pend_full;
  assign busy      = (state != IDLE);

  // Last byte of the current byte-oriented phase.
  always_comb begin
    phase_done = 1'b0;
    case (state)
      PREAMBLE: phase_done = (byte_cnt == 6'(PREAMBLE_BYTES - 1));
      SFD:      phase_done = 1'b1;
      DATA:     phase_done = (byte_cnt == 6'd59);
      FCS:      phase_done = (byte_cnt == 6'd3);
      default:  phase_done = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (use_pend || use_in) state_nxt = PREAMBLE;
      PREAMBLE: if (accept && phase_done) state_nxt = SFD;
      SFD:      if (accept) state_nxt = DATA;
      DATA: begin
        if (accept && phase_done) begin
`ifdef ETH_TX_FCS_EN
          state_nxt = FCS;
`else
          state_nxt = IFG;
`endif
        end
      end
      FCS:      if (accept && phase_done) state_nxt = IFG;
      IFG:      if (ifg_done) state_nxt = (use_pend || use_in) ? PREAMBLE : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Stream outputs are decoded from registered state so they hold during stalls.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    case (state)
      PREAMBLE: begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end
      SFD: begin
        tx_valid = 1'b1;
        tx_data  = 8'hD5;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = shift_reg[479:472];
`ifndef ETH_TX_FCS_EN
        tx_last  = (byte_cnt == 6'd59);
`endif
      end
`ifdef ETH_TX_FCS_EN
      FCS: begin
        tx_valid = 1'b1;
        tx_last  = (byte_cnt == 6'd3);
        case (byte_cnt[1:0])
          2'd0:    tx_data = crc_inv[7:0];
          2'd1:    tx_data = crc_inv[15:8];
          2'd2:    tx_data = crc_inv[23:16];
          default: tx_data = crc_inv[31:24];
        endcase
      end
`endif
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // Byte counter within a phase; wraps to zero on the phase's last byte.
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in)     byte_cnt <= 6'd0;
    else if (accept) byte_cnt <= phase_done ? 6'd0 : byte_cnt + 6'd1;
  end

  // Gap counter runs only while in IFG.
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in)                        ifg_cnt <= '0;
    else if (state == IFG && !ifg_done) ifg_cnt <= ifg_cnt + 1'b1;
    else                                ifg_cnt <= '0;
  end

  // Pending-slot occupancy and the dropped-request pulse.
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) begin
      pend_full <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      dropped <= drop_req;
      if (use_pend)       pend_full <= 1'b0;
      else if (latch_req) pend_full <= 1'b1;
    end
  end

  // Packet storage: pending copy and the outgoing shift register.
  always_ff @(posedge eth_clk) begin
    if (latch_req) pend_data <= eth_packet;
    if (use_pend)                     shift_reg <= pend_data;
    else if (use_in)                  shift_reg <= eth_packet;
    else if (state == DATA && accept) shift_reg <= {shift_reg[471:0], 8'h00};
  end

`ifdef ETH_TX_FCS_EN
  // CRC accumulates accepted DATA bytes; restarts when the SFD goes out.
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in)                      crc <= 32'hFFFFFFFF;
    else if (state == SFD && accept)  crc <= 32'hFFFFFFFF;
    else if (state == DATA && accept) crc <= crc32_byte(crc, shift_reg[479:472]);
  end
`endif

endmodule
